// File: rtl/uart_pkg.sv
// Frame definitions shared by the UART receive and transmit paths.
// Receiver FSM encoding, parity type constants and the majority helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic maj3(logic a, logic b, logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, per-bit edge counter and 3-sample majority voter.
// The counter runs only while the frame FSM is (or is about to be) active.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    input  logic run_i,
    output logic rx_s_o,
    output logic bit_o,
    output logic dec_o,
    output logic wrap_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;

    logic [1:0]    sync_q;
    logic [1:0]    samp_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign rx_s_o = sync_q[1];
    assign wrap_o = (cnt_q == CW'(OVERSAMPLE - 1));
    assign dec_o  = (cnt_q == CW'(M + 1));
    // samp_q holds the synced line at ticks M-1 and M when the counter sits at M+1
    assign bit_o  = maj3(samp_q[1], samp_q[0], sync_q[1]);

    always_comb begin
        cnt_d = '0;
        if (run_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
            samp_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            samp_q <= {samp_q[0], sync_q[1]};
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing on top of the sampler.
// Delivers good words with a valid pulse; parity and stop faults pulse separately.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e             state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  ferr_q, ferr_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;

    logic rx_s;
    logic bit_v;
    logic dec;
    logic wrap;
    logic exp_par;
    logic run;

    assign run = (state_d != IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clk_i (CLK),
        .rst_i (RST),
        .rx_i  (RX_IN),
        .run_i (run),
        .rx_s_o(rx_s),
        .bit_o (bit_v),
        .dec_o (dec),
        .wrap_o(wrap)
    );

    assign exp_par = (^shift_q) ^ (par_typ_q == PAR_ODD);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pdata_d   = pdata_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        ferr_d    = ferr_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    ferr_d    = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (dec && bit_v) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (dec) begin
                    shift_d = {bit_v, shift_q[DATA_WIDTH-1:1]};
                end
                if (wrap) begin
                    if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (dec && (bit_v != exp_par)) begin
                    ferr_d = 1'b1;
                    perr_d = 1'b1;
                end
                if (wrap) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // leave at the decision tick so a back-to-back start bit is not missed
                if (dec) begin
                    state_d = IDLE;
                    if (!bit_v) begin
                        serr_d = 1'b1;
                    end else if (!ferr_q) begin
                        pdata_d = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            pdata_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            ferr_q    <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            pdata_q   <= pdata_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            ferr_q    <= ferr_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
        end
    end

    assign P_DATA     = pdata_q;
    assign data_valid = valid_q;
    assign par_err    = perr_q;
    assign stp_err    = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, hand-built corner sequences,
// and random frames scored against a frame-level reference model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int W  = 8;
    localparam int OS = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         RX_IN;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic [W-1:0] P_DATA;
    logic         data_valid;
    logic         par_err;
    logic         stp_err;

    uart_rx #(
        .DATA_WIDTH(W),
        .OVERSAMPLE(OS)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    always #5 CLK = ~CLK;

    int nvec = 0;
    int nmis = 0;
    int n_valid, n_perr, n_serr;
    logic [W-1:0] got_q[$];

    always @(negedge CLK) begin
        if (data_valid === 1'b1) begin
            n_valid++;
            got_q.push_back(P_DATA);
        end
        if (par_err === 1'b1) n_perr++;
        if (stp_err === 1'b1) n_serr++;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic clr_mon();
        n_valid = 0;
        n_perr  = 0;
        n_serr  = 0;
        got_q.delete();
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic int pick_flip(input int fm);
        if (fm == 0) return -1;
        if (fm == 1) return 4;
        return int'($urandom_range(5, 3));
    endfunction

    task automatic send_bit(input logic lvl, input int flip);
        for (int t = 0; t < OS; t++) begin
            RX_IN = (t == flip) ? ~lvl : lvl;
            cyc(1);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic pen,
                              input logic pbit, input logic stop,
                              input int fm, input logic scramble);
        send_bit(1'b0, pick_flip(fm));
        if (scramble) begin
            PAR_EN  = 1'($urandom);
            PAR_TYP = 1'($urandom);
        end
        for (int i = 0; i < W; i++) send_bit(d[i], pick_flip(fm));
        if (pen) send_bit(pbit, pick_flip(fm));
        send_bit(stop, pick_flip(fm));
    endtask

    task automatic chk_frame(input string nm, input int ev, input int epe,
                             input int ese, input logic [W-1:0] epd);
        chk({nm, "_valid"}, n_valid, ev);
        chk({nm, "_perr"}, n_perr, epe);
        chk({nm, "_serr"}, n_serr, ese);
        chk({nm, "_pdata"}, 32'(P_DATA), 32'(epd));
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic         pen;
        logic         ptyp;
        logic         pbit;
        logic         stop;
        int           fm;
        int           ev;
        int           epe;
        int           ese;
        logic [W-1:0] epd;
        string        nm;
    } vec_t;

    vec_t tbl[7];

    int           ones;
    logic [W-1:0] ref_pd;
    logic [W-1:0] rd;
    logic         rpen, rtyp, rpbit, rstop, good_par, pe;
    logic [W-1:0] g0, g1;

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 0, 0, 8'hA5, "a5"};
        tbl[1] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 8'hA5, "a5_flip"};
        tbl[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 0, 0, 8'h3C, "3c_even_ok"};
        tbl[3] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1, 0, 8'h3C, "3c_even_bad"};
        tbl[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1, 8'h3C, "55_stop0"};
        tbl[5] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 1, 1, 8'h3C, "both_err"};
        tbl[6] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1, 0, 0, 8'h07, "07_odd_ok"};

        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        clr_mon();
        cyc(3);
        RST = 1'b0;
        cyc(2);
        chk("rst_pdata", 32'(P_DATA), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_perr", 32'(par_err), 32'h0);
        chk("rst_serr", 32'(stp_err), 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));

        foreach (tbl[k]) begin
            PAR_EN  = tbl[k].pen;
            PAR_TYP = tbl[k].ptyp;
            clr_mon();
            send_frame(tbl[k].d, tbl[k].pen, tbl[k].pbit, tbl[k].stop,
                       tbl[k].fm, 1'b0);
            RX_IN = 1'b1;
            cyc(6);
            chk_frame(tbl[k].nm, tbl[k].ev, tbl[k].epe, tbl[k].ese, tbl[k].epd);
        end

        // short low glitch: START is entered, then abandoned
        PAR_EN = 1'b0;
        clr_mon();
        RX_IN = 1'b0;
        cyc(3);
        chk("glitch_start", 32'(dut.state_q), 32'(START));
        RX_IN = 1'b1;
        cyc(12);
        chk("glitch_idle", 32'(dut.state_q), 32'(IDLE));
        chk_frame("glitch", 0, 0, 0, 8'h07);

        // back-to-back frames with no idle gap
        clr_mon();
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        RX_IN = 1'b1;
        cyc(6);
        g0 = (got_q.size() > 0) ? got_q[0] : 'x;
        g1 = (got_q.size() > 1) ? got_q[1] : 'x;
        chk("b2b_count", n_valid, 2);
        chk("b2b_first", 32'(g0), 32'h01);
        chk("b2b_second", 32'(g1), 32'hFE);

        // line break: one stop error, then back to idle
        clr_mon();
        RX_IN = 1'b0;
        cyc(80);
        RX_IN = 1'b1;
        cyc(24);
        chk_frame("break", 0, 0, 1, 8'hFE);
        chk("break_idle", 32'(dut.state_q), 32'(IDLE));

        // reset in the middle of data bit 4
        clr_mon();
        send_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, -1);
        RX_IN = 1'b0;
        cyc(4);
        chk("mid_state", 32'(dut.state_q), 32'(DATA));
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        RX_IN = 1'b1;
        chk("mrst_state", 32'(dut.state_q), 32'(IDLE));
        chk("mrst_pdata", 32'(P_DATA), 32'h0);
        chk("mrst_flags", 32'({data_valid, par_err, stp_err}), 32'h0);
        cyc(10);
        clr_mon();
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        RX_IN = 1'b1;
        cyc(6);
        chk_frame("after_rst", 1, 0, 0, 8'h81);

        // random frames against the frame-level model
        ref_pd = 8'h81;
        for (int n = 0; n < 40; n++) begin
            rd    = W'($urandom);
            rpen  = 1'($urandom);
            rtyp  = 1'($urandom);
            ones  = 0;
            for (int i = 0; i < W; i++) ones += int'(rd[i]);
            good_par = ((ones % 2) == 1) ^ (rtyp == PAR_ODD);
            rpbit = ($urandom_range(3, 0) == 0) ? ~good_par : good_par;
            rstop = ($urandom_range(4, 0) != 0);
            pe    = rpen && (rpbit != good_par);
            if (!pe && rstop) ref_pd = rd;
            PAR_EN  = rpen;
            PAR_TYP = rtyp;
            clr_mon();
            send_frame(rd, rpen, rpbit, rstop, 2, 1'b1);
            RX_IN = 1'b1;
            cyc(6);
            chk_frame($sformatf("rnd%0d", n), int'(!pe && rstop), int'(pe),
                      int'(!rstop), ref_pd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
